// File: rtl/noc_packetizer.sv
// noc_packetizer: source-side NoC interface turning requests and payload words into a flit stream
module noc_packetizer #(
  parameter int NOC_WIDTH = 4,
  parameter int NOC_LENGTH = 4,
  parameter int ROUTER_ID = 0,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_PAYLOAD = 4,
  localparam int XW = $clog2(NOC_WIDTH),
  localparam int YW = $clog2(NOC_LENGTH),
  localparam int TAW = XW + YW,
  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [XW-1:0]         req_dest_x,
  input  logic [YW-1:0]         req_dest_y,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [1:0]            flit_type,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic                  err,
  output logic                  busy
);
  typedef enum logic {IDLE, BODY} state_t;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;
  state_t state, state_nx;
  logic [LEN_W-1:0] rem, rem_nx;
  logic [7:0] seq;
  logic slot, req_fire, data_fire, legal, load, hdr_load;
  logic [1:0] type_nx;
  logic [DATA_WIDTH-1:0] data_nx, hdr;
  assign slot = !flit_valid || flit_ready;
  assign req_ready = state == IDLE && slot;
  assign data_ready = state == BODY && slot;
  assign req_fire = req_valid && req_ready;
  assign data_fire = data_valid && data_ready;
  assign legal = 32'(req_dest_x) < NOC_WIDTH && 32'(req_dest_y) < NOC_LENGTH && 32'(req_len) <= MAX_PAYLOAD;
  assign hdr = DATA_WIDTH'({seq, req_len, TAW'(ROUTER_ID), req_dest_y, req_dest_x});
  assign busy = state != IDLE;
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state, remaining count and the flit to load this cycle
  always_comb begin
    state_nx = state;
    rem_nx = rem;
    load = 1'b0;
    hdr_load = 1'b0;
    type_nx = T_BODY;
    data_nx = data_in;
    if (req_fire && legal) begin
      load = 1'b1;
      hdr_load = 1'b1;
      type_nx = req_len == '0 ? T_HT : T_HEAD;
      data_nx = hdr;
      rem_nx = req_len;
      state_nx = req_len == '0 ? IDLE : BODY;
    end else if (data_fire) begin
      load = 1'b1;
      type_nx = rem == LEN_W'(1) ? T_TAIL : T_BODY;
      rem_nx = rem - LEN_W'(1);
      state_nx = rem == LEN_W'(1) ? IDLE : BODY;
    end
  end
  // flit output register, sequence counter and error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      seq <= '0;
      err <= 1'b0;
      flit_valid <= 1'b0;
      flit_type <= T_BODY;
      flit_data <= '0;
    end else begin
      rem <= rem_nx;
      err <= req_fire && !legal;
      if (hdr_load) seq <= seq + 8'd1;
      if (slot) begin
        flit_valid <= load;
        if (load) begin
          flit_type <= type_nx;
          flit_data <= data_nx;
        end
      end
    end
endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: randomized and directed checks of noc_packetizer against a packet-level model
module tb_noc_packetizer;
  localparam int NW = 4, NL = 4, RID = 5, MP = 4, DW = 32;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready;
  logic [1:0] req_dest_x = 0, req_dest_y = 0;
  logic [2:0] req_len = 0;
  logic data_valid = 0, data_ready;
  logic [DW-1:0] data_in = 0;
  logic flit_valid, flit_ready = 1;
  logic [1:0] flit_type;
  logic [DW-1:0] flit_data;
  logic err, busy;
  logic [33:0] exp_q[$], log_q[$];
  int cyc_q[$];
  int n_cmp = 0, n_bad = 0, m_seq = 0, m_err = 0, err_seen = 0, stall_cnt = 0, cyc = 0;
  bit rnd_bp = 0, stalled = 0;
  logic [1:0] h_t;
  logic [DW-1:0] h_d;
  logic [31:0] none[$];

  noc_packetizer #(.NOC_WIDTH(NW), .NOC_LENGTH(NL), .ROUTER_ID(RID), .DATA_WIDTH(DW), .MAX_PAYLOAD(MP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_type(flit_type), .flit_data(flit_data),
    .err(err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // random back-pressure source
  always @(posedge clk) begin
    #1;
    if (rnd_bp) flit_ready = $urandom_range(0, 3) != 0;
  end

  // consumed-flit scoreboard, hold-stability and error-pulse monitor
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (stalled) begin
        check("hold_valid", flit_valid, 1);
        check("hold_type", flit_type, h_t);
        check("hold_data", flit_data, h_d);
      end
      if (flit_valid && flit_ready) begin
        log_q.push_back({flit_type, flit_data});
        cyc_q.push_back(cyc);
        check("flit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("flit", {flit_type, flit_data}, exp_q.pop_front());
      end
      if (flit_valid && !flit_ready) begin
        stall_cnt++;
        check("data_ready_full", data_ready, 0);
        check("req_ready_full", req_ready, 0);
      end
      stalled = flit_valid && !flit_ready;
      h_t = flit_type;
      h_d = flit_data;
      if (err) err_seen++;
    end
  end

  task automatic send_req(input int x, input int y, input int len, input bit legal);
    bit ok = 0;
    req_valid = 1;
    req_dest_x = 2'(x);
    req_dest_y = 2'(y);
    req_len = 3'(len);
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      tick(1);
    end
    req_valid = 0;
    check("req_accept", ok, 1);
    check("err_pulse", err, !legal);
    if (legal) check("hdr_latency", flit_valid, 1);
  endtask

  task automatic send_data(input logic [31:0] w[$], input bit gaps);
    bit ok;
    foreach (w[i]) begin
      if (gaps) tick($urandom_range(0, 2));
      data_valid = 1;
      data_in = w[i];
      ok = 0;
      for (int k = 0; k < 1000 && !ok; k++) begin
        @(negedge clk);
        ok = data_ready;
        tick(1);
      end
      data_valid = 0;
      check("data_accept", ok, 1);
    end
  endtask

  // model: a legal packet is its header then its words, last one TAIL
  task automatic pkt(input int x, input int y, input int len, input logic [31:0] w[$], input bit gaps);
    bit legal = x < NW && y < NL && len <= MP;
    logic [31:0] h = 32'(y * NW + x + 16 * RID + 256 * len + 2048 * m_seq);
    if (legal) begin
      exp_q.push_back({len == 0 ? 2'b11 : 2'b01, h});
      foreach (w[i]) exp_q.push_back({i == w.size() - 1 ? 2'b10 : 2'b00, w[i]});
      m_seq = (m_seq + 1) % 256;
    end else m_err++;
    send_req(x, y, len, legal);
    if (legal && len > 0) send_data(w, gaps);
  endtask

  initial begin
    logic [31:0] w[$];
    int x, y, len;
    tick(2);
    check("rst_flit_valid", flit_valid, 0);
    check("rst_flit_type", flit_type, 0);
    check("rst_flit_data", flit_data, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_data_ready", data_ready, 0);
    rst_n = 1;
    tick(1);
    check("idle_flit_valid", flit_valid, 0);

    pkt(3, 2, 2, '{32'hAAAA0001, 32'hAAAA0002}, 0);
    check("busy_after_tail", busy, 0);
    tick(1);
    check("basic_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("basic_head", log_q[0], {2'b01, 32'h0000025B});
      check("basic_body", log_q[1], {2'b00, 32'hAAAA0001});
      check("basic_tail", log_q[2], {2'b10, 32'hAAAA0002});
      check("basic_gap1", cyc_q[1] - cyc_q[0], 1);
      check("basic_gap2", cyc_q[2] - cyc_q[1], 1);
    end

    log_q.delete();
    pkt(0, 0, 0, none, 0);
    tick(1);
    check("zero_count", log_q.size(), 1);
    if (log_q.size() == 1) check("zero_headtail", log_q[0], {2'b11, 32'h00000850});

    stall_cnt = 0;
    fork
      pkt(1, 2, 3, '{32'hB0000001, 32'hB0000002, 32'hB0000003}, 0);
      begin
        tick(2);
        flit_ready = 0;
        tick(3);
        flit_ready = 1;
      end
    join
    tick(2);
    check("bp_stalled", stall_cnt >= 3, 1);

    pkt(1, 1, 5, none, 0);
    tick(1);
    check("rej_busy", busy, 0);
    check("rej_no_flit", flit_valid, 0);
    log_q.delete();
    pkt(2, 3, 1, '{32'hC0DE0001}, 0);
    tick(1);
    check("rej_next_count", log_q.size(), 2);
    if (log_q.size() == 2) check("rej_next_seq", log_q[0][18:11], 3);

    rnd_bp = 1;
    for (int p = 0; p < 150; p++) begin
      x = $urandom_range(0, 3);
      y = $urandom_range(0, 3);
      len = $urandom_range(0, 7);
      w.delete();
      if (len <= MP) for (int i = 0; i < len; i++) w.push_back($urandom);
      pkt(x, y, len, w, 1);
      tick($urandom_range(0, 2));
    end
    rnd_bp = 0;
    tick(1);
    flit_ready = 1;
    tick(5);
    check("drained", exp_q.size(), 0);

    send_req(2, 1, 4, 1);
    rst_n = 0;
    #1;
    check("mid_rst_valid", flit_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data_ready", data_ready, 0);
    m_seq = 0;
    tick(2);
    rst_n = 1;
    tick(1);

    log_q.delete();
    for (int p = 0; p < 257; p++) pkt($urandom_range(0, 3), $urandom_range(0, 3), 0, none, 0);
    tick(2);
    check("wrap_count", log_q.size(), 257);
    if (log_q.size() == 257) begin
      check("seq_after_rst", log_q[0][18:11], 0);
      check("seq_255", log_q[255][18:11], 255);
      check("seq_wrap", log_q[256][18:11], 0);
      check("wrap_type", log_q[256][33:32], 2'b11);
    end

    check("final_queue", exp_q.size(), 0);
    check("err_pulses", err_seen, m_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/noc_packetizer.md
# noc_packetizer

Source-side network interface for one mesh node: accepts a message request (destination X/Y coordinates plus payload length) and a payload word stream from the local core. It emits a flit stream into the router's local input port: a header flit carrying the packed destination address that the router's X-Y port decoder routes on, then body/tail flits. Requests with out-of-range coordinates or lengths are rejected with an error pulse, and no flits are emitted for them.

## Interface
- `NOC_WIDTH`, 4: mesh columns; must be at least 2.
- `NOC_LENGTH`, 4: mesh rows; must be at least 2.
- `ROUTER_ID`, 0: this node's packed address, `{y, x}`.
- `DATA_WIDTH`, 32: flit payload width; must be at least 2·TAW + LEN_W + 8.
- `MAX_PAYLOAD`, 4: maximum body words per packet.
- Derived widths:
  - XW = $clog2(NOC_WIDTH), YW = $clog2(NOC_LENGTH), TAW = XW + YW.
  - LEN_W = $clog2(MAX_PAYLOAD + 1).
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_dest_x`  in  XW  destination column.
- `req_dest_y`  in  YW  destination row.
- `req_len`  in  LEN_W  payload word count, 0..MAX_PAYLOAD.
- `data_valid`  in  1  payload word present.
- `data_ready`  out  1  payload word accepted.
- `data_in`  in  DATA_WIDTH  payload word.
- `flit_valid`  out  1  flit present to router local port.
- `flit_ready`  in  1  router accepts flit.
- `flit_type`  out  2  flit type:
  - 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEADTAIL.
- `flit_data`  out  DATA_WIDTH  flit payload.
- `err`  out  1  one-cycle pulse on a rejected request.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- FSM states: IDLE, BODY.
- Output register: a single flit register holds `flit_valid`, `flit_type`, `flit_data`.
  - It may load when `!flit_valid || flit_ready` (the "slot" condition).
  - It holds its contents while `flit_valid && !flit_ready`.
- `req_ready` = IDLE && slot.
- `data_ready` = BODY && slot.
- Request check, applied on acceptance:
  - Legal when `req_dest_x < NOC_WIDTH`, `req_dest_y < NOC_LENGTH`, and `req_len <= MAX_PAYLOAD`.
  - Illegal request: no flit is loaded, `err` = 1 next cycle, FSM stays in IDLE, seq is unchanged. The sender must not supply payload for a rejected request.
- Header `flit_data` layout (bits not listed are zero):
  - [TAW-1:0] dest_addr = (req_dest_y << XW) | req_dest_x.
  - [2·TAW-1:TAW] src = ROUTER_ID.
  - next LEN_W bits: req_len.
  - next 8 bits: seq.
- Legal request with len 0: load a HEADTAIL flit; FSM stays in IDLE.
- Legal request with len > 0: load a HEAD flit; latch remaining = len; go to BODY.
- BODY state, on each data handshake:
  - Load `data_in` as a flit.
  - Type is TAIL if remaining == 1, else BODY.
  - Decrement remaining; on TAIL return to IDLE.
- seq: 8-bit counter.
  - Increments on each legal header (HEAD or HEADTAIL) loaded.
  - Wraps 255 -> 0.
- dest == ROUTER_ID is legal and is packetized normally.

## Timing
- Reset values: `flit_valid` 0, `flit_type` 2'b00, `flit_data` 0, `err` 0, `busy` 0, seq 0, FSM IDLE.
  - `req_ready` is 1 out of reset (IDLE with an empty slot); `data_ready` is 0.
- Reset asserted mid-packet clears state immediately. A partially sent packet is abandoned; no tail is generated.
- Latency:
  - A request accepted at edge N gives a header valid after edge N.
  - A data word accepted at edge N gives its flit valid after edge N.
- Throughput: one flit per cycle while `flit_ready` is held high.
- Back-to-back packets: a request is accepted in the same cycle the TAIL is being consumed (IDLE && `flit_ready`), giving zero bubbles.
- `flit_*` must stay stable while `flit_valid && !flit_ready`.
- `err` is high for exactly one cycle per rejected request.

## Test plan
All cases use defaults with ROUTER_ID = 5 (x=1, y=1), so TAW = 4 and LEN_W = 3.
- Basic two-word packet: request x=3, y=2, len=2, then data 0xAAAA0001, 0xAAAA0002, with `flit_ready` held 1.
  - Expect flits HEAD 0x0000025B, BODY 0xAAAA0001, TAIL 0xAAAA0002 on three consecutive cycles.
  - Expect `busy` to fall after the TAIL.
- Zero-length packet: request x=0, y=0, len=0 as the second packet after reset.
  - Expect a single HEADTAIL flit 0x00000850 (seq = 1).
- Back-pressure: drop `flit_ready` for 3 cycles mid-packet.
  - Expect flit held stable, `data_ready` = 0 while the slot is full, and no word lost or duplicated.
- Rejected requests: request x=1, y=4, len=1 (Y out of range only if NOC_LENGTH = 4 is widened to YW bits — use len=5 instead).
  - Expect `err` pulse, no `flit_valid`, seq unchanged, and the next legal packet still correct.
- seq wrap: send 257 zero-length packets.
  - Expect header seq to wrap 255 -> 0, with packet 257 carrying seq 0.
- Reset mid-packet: assert `rst_n` = 0 after the HEAD of a len=4 packet.
  - Expect `flit_valid` = 0 and `busy` = 0 immediately.
  - After release, the next packet's header carries seq 0.
